// File: rtl/slc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slc3_pkg
// Description : Shared definitions for the SLC-3 test top. Contains the opcode
//               and FSM state enums, the I/O address, the blank 7-segment
//               pattern and the boot image of the program/data memory.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package slc3_pkg;

    // Memory-mapped switch/hex I/O lives at the top of the address space.
    localparam logic [15:0] IO_ADDR   = 16'hFFFF;
    // Active-low segments: all ones turns every segment off.
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    typedef enum logic [3:0] {
        OP_BR    = 4'b0000,
        OP_ADD   = 4'b0001,
        OP_JSR   = 4'b0100,
        OP_AND   = 4'b0101,
        OP_LDR   = 4'b0110,
        OP_STR   = 4'b0111,
        OP_NOT   = 4'b1001,
        OP_JMP   = 4'b1100,
        OP_PAUSE = 4'b1101
    } opcode_e;

    typedef enum logic [4:0] {
        HALTED    = 5'd0,
        FETCH1    = 5'd1,
        FETCH2    = 5'd2,
        FETCH3    = 5'd3,
        DECODE    = 5'd4,
        EX_ADD    = 5'd5,
        EX_AND    = 5'd6,
        EX_NOT    = 5'd7,
        EX_BR     = 5'd8,
        EX_JMP    = 5'd9,
        EX_JSR    = 5'd10,
        EX_LDR1   = 5'd11,
        EX_LDR2   = 5'd12,
        EX_STR1   = 5'd13,
        EX_STR2   = 5'd14,
        PAUSE_IR1 = 5'd15,
        PAUSE_IR2 = 5'd16
    } state_e;

    // Boot image: three I/O test programs selected by jumping to the
    // switch value (x03, x06 or x0B). Every other word is zero.
    function automatic logic [15:0] boot_word(input logic [7:0] addr);
        logic [15:0] w;
        case (addr)
            8'h00:   w = 16'h5020; // AND R0,R0,#0
            8'h01:   w = 16'h623F; // LDR R1,R0,#-1
            8'h02:   w = 16'hC040; // JMP R1
            8'h03:   w = 16'h623F; // LDR R1,R0,#-1
            8'h04:   w = 16'h723F; // STR R1,R0,#-1
            8'h05:   w = 16'h0FFD; // BRnzp x03
            8'h06:   w = 16'hD001; // PAUSE x001
            8'h07:   w = 16'h623F; // LDR R1,R0,#-1
            8'h08:   w = 16'h723F; // STR R1,R0,#-1
            8'h09:   w = 16'h0FFC; // BRnzp x06
            8'h0A:   w = 16'h0000; // NOP (BR with no condition bits)
            8'h0B:   w = 16'hD002; // PAUSE x002
            8'h0C:   w = 16'h623F; // LDR R1,R0,#-1
            8'h0D:   w = 16'h1261; // ADD R1,R1,#1
            8'h0E:   w = 16'h723F; // STR R1,R0,#-1
            8'h0F:   w = 16'h0FFB; // BRnzp x0B
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_driver.sv
`default_nettype none
// ============================================================================
// Module      : hex_driver
// Description : Nibble to 7-segment decoder, active-low segments {g,f,e,d,c,b,a}.
// Ports       : in_i  [3:0] - nibble to display
//               seg_o [6:0] - active-low segment pattern
// Revision    : 1.0 - initial release
// ============================================================================
module hex_driver (
    input  logic [3:0] in_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (in_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/slc3_testtop.sv
`default_nettype none
// ============================================================================
// Module      : slc3_testtop
// Description : Minimal 16-bit SLC-3 core with internal boot memory, switch
//               input and hex output at xFFFF, and a PAUSE instruction that
//               shows a code on the LEDs until Continue is pressed/released.
//               Optional macro SLC3_DEBUG_HEX_EN: show IR on HEX3..0 and
//               PC[7:0] on HEX5..4 instead of the HexOut register.
// Ports       : Clk              - system clock, rising edge
//               Run              - active-low Run pushbutton
//               Continue         - active-low Continue pushbutton
//               SW   [9:0]       - switches, read at xFFFF
//               LED  [9:0]       - pause code
//               HEX0..HEX5 [6:0] - active-low 7-segment displays
//               Reset is internal: both buttons held low (asynchronous).
// Revision    : 1.0 - initial release
// ============================================================================
module slc3_testtop
    import slc3_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic       Clk,
    input  logic       Run,
    input  logic       Continue,
    input  logic [9:0] SW,
    output logic [9:0] LED,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int AW = $clog2(MEM_WORDS);

    logic reset;
    assign reset = ~Run & ~Continue;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [9:0]  led_q, led_d;
    logic [15:0] hexout_q, hexout_d;
    logic [15:0] regs_q [8];
    logic [15:0] mem_q  [MEM_WORDS];

    logic        rf_we;
    logic [2:0]  rf_dest;
    logic [15:0] rf_wdata;
    logic        set_cc;
    logic        mem_we;

    opcode_e     opcode;
    logic [15:0] sr1_val, sr2_val, dr_val, alu_b, mem_rdata;
    logic [15:0] sext5, sext6, sext9, sext11;

    assign opcode  = opcode_e'(ir_q[15:12]);
    assign sr1_val = regs_q[ir_q[8:6]];
    assign sr2_val = regs_q[ir_q[2:0]];
    assign dr_val  = regs_q[ir_q[11:9]];
    assign sext5   = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sext6   = {{10{ir_q[5]}}, ir_q[5:0]};
    assign sext9   = {{7{ir_q[8]}},  ir_q[8:0]};
    assign sext11  = {{5{ir_q[10]}}, ir_q[10:0]};
    assign alu_b   = ir_q[5] ? sext5 : sr2_val;

    // Everything except the I/O word aliases onto the low address bits.
    assign mem_rdata = (mar_q == IO_ADDR) ? {6'b0, SW} : mem_q[mar_q[AW-1:0]];

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        led_d    = led_q;
        hexout_d = hexout_q;
        rf_we    = 1'b0;
        rf_dest  = ir_q[11:9];
        rf_wdata = 16'h0000;
        set_cc   = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            HALTED: if (!Run) state_d = FETCH1;
            FETCH1: begin
                mar_d   = pc_q;
                pc_d    = pc_q + 16'd1;
                state_d = FETCH2;
            end
            FETCH2: begin
                mdr_d   = mem_rdata;
                state_d = FETCH3;
            end
            FETCH3: begin
                ir_d    = mdr_q;
                state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_ADD:   state_d = EX_ADD;
                    OP_AND:   state_d = EX_AND;
                    OP_NOT:   state_d = EX_NOT;
                    OP_BR:    state_d = EX_BR;
                    OP_JMP:   state_d = EX_JMP;
                    OP_JSR:   state_d = EX_JSR;
                    OP_LDR:   state_d = EX_LDR1;
                    OP_STR:   state_d = EX_STR1;
                    OP_PAUSE: begin
                        led_d   = ir_q[9:0];
                        state_d = PAUSE_IR1;
                    end
                    default:  state_d = FETCH1;
                endcase
            end
            EX_ADD: begin
                rf_we = 1'b1; set_cc = 1'b1;
                rf_wdata = sr1_val + alu_b;
                state_d  = FETCH1;
            end
            EX_AND: begin
                rf_we = 1'b1; set_cc = 1'b1;
                rf_wdata = sr1_val & alu_b;
                state_d  = FETCH1;
            end
            EX_NOT: begin
                rf_we = 1'b1; set_cc = 1'b1;
                rf_wdata = ~sr1_val;
                state_d  = FETCH1;
            end
            EX_BR: begin
                if (|(ir_q[11:9] & nzp_q)) pc_d = pc_q + sext9;
                state_d = FETCH1;
            end
            EX_JMP: begin
                pc_d    = sr1_val;
                state_d = FETCH1;
            end
            EX_JSR: begin
                // Link uses the old PC; the base register read is also pre-write.
                rf_we    = 1'b1;
                rf_dest  = 3'd7;
                rf_wdata = pc_q;
                pc_d     = ir_q[11] ? (pc_q + sext11) : sr1_val;
                state_d  = FETCH1;
            end
            EX_LDR1: begin
                mar_d   = sr1_val + sext6;
                state_d = EX_LDR2;
            end
            EX_LDR2: begin
                mdr_d    = mem_rdata;
                rf_we    = 1'b1; set_cc = 1'b1;
                rf_wdata = mem_rdata;
                state_d  = FETCH1;
            end
            EX_STR1: begin
                mar_d   = sr1_val + sext6;
                mdr_d   = dr_val;
                state_d = EX_STR2;
            end
            EX_STR2: begin
                if (mar_q == IO_ADDR) hexout_d = mdr_q;
                else                  mem_we   = 1'b1;
                state_d = FETCH1;
            end
            // Two-phase handshake: one instruction pass per press/release.
            PAUSE_IR1: if (!Continue) state_d = PAUSE_IR2;
            PAUSE_IR2: if (Continue)  state_d = FETCH1;
            default:   state_d = HALTED;
        endcase

        nzp_d = nzp_q;
        if (set_cc)
            nzp_d = {rf_wdata[15], (rf_wdata == 16'h0000),
                     (~rf_wdata[15] & (rf_wdata != 16'h0000))};
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state_q <= HALTED;
        else       state_q <= state_d;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            pc_q     <= 16'h0000;
            ir_q     <= 16'h0000;
            mar_q    <= 16'h0000;
            mdr_q    <= 16'h0000;
            nzp_q    <= 3'b000;
            led_q    <= 10'h000;
            hexout_q <= 16'h0000;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            nzp_q    <= nzp_d;
            led_q    <= led_d;
            hexout_q <= hexout_d;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
        end else if (rf_we) begin
            regs_q[rf_dest] <= rf_wdata;
        end
    end

    // Reset reloads the boot image so programs always start from a known state.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= boot_word(8'(i));
        end else if (mem_we) begin
            mem_q[mar_q[AW-1:0]] <= mdr_q;
        end
    end

    assign LED = led_q;

    // ------------------------------------------------------------------
    // Hex displays
    // ------------------------------------------------------------------
    logic [23:0] hex_val;
    logic [5:0]  hex_blank;
    logic [6:0]  seg_raw [6];
    logic [6:0]  seg_out [6];

`ifdef SLC3_DEBUG_HEX_EN
    assign hex_val   = {pc_q[7:0], ir_q};
    assign hex_blank = 6'b000000;
`else
    assign hex_val   = {8'h00, hexout_q};
    assign hex_blank = 6'b110000;
`endif

    generate
        for (genvar g = 0; g < 6; g++) begin : g_hex
            hex_driver u_hex (
                .in_i  (hex_val[4*g +: 4]),
                .seg_o (seg_raw[g])
            );
            assign seg_out[g] = hex_blank[g] ? SEG_BLANK : seg_raw[g];
        end
    endgenerate

    assign HEX0 = seg_out[0];
    assign HEX1 = seg_out[1];
    assign HEX2 = seg_out[2];
    assign HEX3 = seg_out[3];
    assign HEX4 = seg_out[4];
    assign HEX5 = seg_out[5];

endmodule
`default_nettype wire

// File: tb/tb_slc3_testtop.sv
`default_nettype none
// ============================================================================
// Module      : tb_slc3_testtop
// Description : Self-checking bench for slc3_testtop. Drives the three boot
//               I/O programs with random switch values and compares HexOut,
//               LED, display segments and FSM state against a program-level
//               model of what each test program should produce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slc3_testtop;
    import slc3_pkg::*;

    logic       Clk = 1'b0;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [9:0] SW = 10'h000;
    logic [9:0] LED;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int total = 0;
    int bad   = 0;

    slc3_testtop #(.MEM_WORDS(256)) dut (
        .Clk      (Clk),
        .Run      (Run),
        .Continue (Continue),
        .SW       (SW),
        .LED      (LED),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    always #5 Clk = ~Clk;

    // Program-level model: what the program entered at 'entry' stores to HexOut.
    function automatic logic [15:0] model_hex(input logic [9:0] sw, input int entry);
        logic [15:0] v;
        v = {6'b0, sw};
        if (entry == 11) v = v + 16'd1;
        return v;
    endfunction

    // Standard active-low {g,f,e,d,c,b,a} digit patterns.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_hex(input string tag, input logic [15:0] exp, input int budget);
        int n = 0;
        while (dut.hexout_q !== exp && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check(tag, 32'(dut.hexout_q), 32'(exp));
    endtask

    task automatic wait_state(input string tag, input state_e st, input int budget);
        int n = 0;
        while (dut.state_q !== st && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check(tag, 32'(dut.state_q), 32'(st));
    endtask

    task automatic check_digits(input string tag, input logic [15:0] v);
        check({tag, "_hex0"}, 32'(HEX0), 32'(seg7(v[3:0])));
        check({tag, "_hex1"}, 32'(HEX1), 32'(seg7(v[7:4])));
        check({tag, "_hex2"}, 32'(HEX2), 32'(seg7(v[11:8])));
        check({tag, "_hex3"}, 32'(HEX3), 32'(seg7(v[15:12])));
        check({tag, "_hex45"}, {18'(0), HEX5, HEX4}, {18'(0), SEG_BLANK, SEG_BLANK});
    endtask

    task automatic do_reset();
        Run = 1'b0; Continue = 1'b0;
        tick(2);
        Run = 1'b1; Continue = 1'b1;
        tick(2);
    endtask

    task automatic start_prog(input logic [9:0] sw);
        SW  = sw;
        Run = 1'b0;
        tick(2);
        Run = 1'b1;
    endtask

    task automatic press_continue();
        Continue = 1'b0;
        tick(2);
        Continue = 1'b1;
    endtask

    initial begin
        logic [9:0]  r;
        logic [15:0] prev;

        // Power-on reset: both buttons low.
        tick(3);
        check("rst_pc",     32'(dut.pc_q),     32'h0);
        check("rst_led",    32'(LED),          32'h0);
        check("rst_hexout", 32'(dut.hexout_q), 32'h0);
        check("rst_state",  32'(dut.state_q),  32'(HALTED));
        check_digits("rst", 16'h0000);

        Run = 1'b1; Continue = 1'b1;
        tick(5);
        check("idle_halted", 32'(dut.state_q), 32'(HALTED));
        check("idle_pc",     32'(dut.pc_q),    32'h0);

        // I/O test 1: switches echoed to HexOut continuously.
        start_prog(10'h003);
        wait_hex("t1_first", model_hex(10'h003, 3), 30);
        check_digits("t1_first", 16'h0003);
        for (int i = 0; i < 6; i++) begin
            r = 10'($urandom_range(0, 1023));
            SW = r;
            wait_hex("t1_rand", model_hex(r, 3), 60);
            check_digits("t1_rand", model_hex(r, 3));
        end

        // I/O test 2: pause with code 1, one echo per Continue press/release.
        do_reset();
        start_prog(10'h006);
        wait_state("t2_pause", PAUSE_IR1, 40);
        check("t2_led",    32'(LED),          32'h001);
        check("t2_hexout", 32'(dut.hexout_q), 32'h0);

        // Run outside HALTED is ignored.
        Run = 1'b0;
        tick(3);
        Run = 1'b1;
        tick(1);
        check("t2_run_ign_state", 32'(dut.state_q), 32'(PAUSE_IR1));
        check("t2_run_ign_pc",    32'(dut.pc_q),    32'h7);

        prev = 16'h0;
        for (int i = 0; i < 4; i++) begin
            r = 10'($urandom_range(0, 1023));
            SW = r;
            press_continue();
            wait_hex("t2_echo", model_hex(r, 6), 20);
            wait_state("t2_repause", PAUSE_IR1, 20);
            check("t2_led_again", 32'(LED), 32'h001);
            prev = model_hex(r, 6);
        end

        // Continue held low: no pass until it is released.
        r = prev[9:0] ^ 10'h155;
        SW = r;
        Continue = 1'b0;
        tick(50);
        check("hold_state",  32'(dut.state_q),  32'(PAUSE_IR2));
        check("hold_hexout", 32'(dut.hexout_q), 32'(prev));
        Continue = 1'b1;
        wait_hex("hold_release", model_hex(r, 6), 20);
        wait_state("hold_repause", PAUSE_IR1, 20);
        tick(30);
        check("hold_single_pass", 32'(dut.state_q), 32'(PAUSE_IR1));

        // Reset while paused takes effect without a clock edge.
        Run = 1'b0; Continue = 1'b0;
        #1;
        check("midrst_pc",     32'(dut.pc_q),     32'h0);
        check("midrst_led",    32'(LED),          32'h0);
        check("midrst_hexout", 32'(dut.hexout_q), 32'h0);
        check("midrst_state",  32'(dut.state_q),  32'(HALTED));
        tick(2);
        Run = 1'b1; Continue = 1'b1;
        tick(2);

        // I/O test 3: pause with code 2, each pass stores SW+1.
        start_prog(10'h00B);
        wait_state("t3_pause", PAUSE_IR1, 40);
        check("t3_led", 32'(LED), 32'h002);
        check("t3_first_inc", 32'(dut.hexout_q), 32'h0);
        SW = 10'h00B;
        press_continue();
        wait_hex("t3_c", model_hex(10'h00B, 11), 20);
        check_digits("t3_c", 16'h000C);
        wait_state("t3_repause_c", PAUSE_IR1, 20);
        for (int i = 0; i < 4; i++) begin
            r = (i == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
            SW = r;
            press_continue();
            wait_hex("t3_inc", model_hex(r, 11), 20);
            wait_state("t3_repause", PAUSE_IR1, 20);
            check("t3_led_again", 32'(LED), 32'h002);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
